// File: rtl/ex_operand_stage_if.sv
// ID/EX operand-stage bus: ID-side operand sources and controls in, registered EX operands out.
interface ex_operand_stage_if #(
  parameter int AWIDTH       = 32,
  parameter int OPCODE_WIDTH = 6,
  parameter int IMM_WIDTH    = 16
);
  logic                    in_valid;
  logic                    stall;
  logic                    flush;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [IMM_WIDTH-1:0]    imm;
  logic [AWIDTH-1:0]       rs_data;
  logic [AWIDTH-1:0]       rt_data;
  logic [AWIDTH-1:0]       exmem_result;
  logic [AWIDTH-1:0]       memwb_result;
  logic [1:0]              fwd_a_sel;
  logic [1:0]              fwd_b_sel;
  logic                    out_valid;
  logic [AWIDTH-1:0]       out_a;
  logic [AWIDTH-1:0]       out_b;
  logic [AWIDTH-1:0]       out_store_data;
  logic                    out_illegal;

  modport master (
    output in_valid, stall, flush, opcode, imm, rs_data, rt_data,
           exmem_result, memwb_result, fwd_a_sel, fwd_b_sel,
    input  out_valid, out_a, out_b, out_store_data, out_illegal
  );

  modport slave (
    input  in_valid, stall, flush, opcode, imm, rs_data, rt_data,
           exmem_result, memwb_result, fwd_a_sel, fwd_b_sel,
    output out_valid, out_a, out_b, out_store_data, out_illegal
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: forwarding muxes, opcode-driven immediate extension and the
// stall/flush-controlled EX operand register.
module ex_operand_stage #(
  parameter int AWIDTH       = 32,
  parameter int OPCODE_WIDTH = 6,
  parameter int IMM_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ex_operand_stage_if.slave     bus
);
  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'h00);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'h08);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDIU = OPCODE_WIDTH'(6'h09);
  localparam logic [OPCODE_WIDTH-1:0] OP_SLTI  = OPCODE_WIDTH'(6'h0A);
  localparam logic [OPCODE_WIDTH-1:0] OP_SLTIU = OPCODE_WIDTH'(6'h0B);
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = OPCODE_WIDTH'(6'h0C);
  localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = OPCODE_WIDTH'(6'h0D);
  localparam logic [OPCODE_WIDTH-1:0] OP_XORI  = OPCODE_WIDTH'(6'h0E);
  localparam logic [OPCODE_WIDTH-1:0] OP_LUI   = OPCODE_WIDTH'(6'h0F);
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(6'h23);
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(6'h2B);

  logic [AWIDTH-1:0] fa, fb, sext, zext, uimm;
  logic [AWIDTH-1:0] a_d, b_d, sd_d;
  logic              illegal, vld_d, ill_d;
  logic [AWIDTH-1:0] a_q, b_q, sd_q;
  logic              vld_q, ill_q;

  // Forwarding: code 11 falls back to the register file, same as 00.
  always_comb begin
    fa = bus.rs_data;
    case (bus.fwd_a_sel)
      2'b01:   fa = bus.exmem_result;
      2'b10:   fa = bus.memwb_result;
      default: fa = bus.rs_data;
    endcase
    fb = bus.rt_data;
    case (bus.fwd_b_sel)
      2'b01:   fb = bus.exmem_result;
      2'b10:   fb = bus.memwb_result;
      default: fb = bus.rt_data;
    endcase
  end

  assign sext = AWIDTH'($signed(bus.imm));
  assign zext = AWIDTH'(bus.imm);
  // Shift rather than concatenation so AWIDTH == 2*IMM_WIDTH needs no zero-width replicate.
  assign uimm = zext << IMM_WIDTH;

  always_comb begin
    illegal = 1'b0;
    a_d     = fa;
    b_d     = '0;
    sd_d    = fb;
    case (bus.opcode)
      OP_RTYPE:                   b_d = fb;
      OP_LOAD, OP_STORE, OP_ADDI,
      OP_ADDIU, OP_SLTI, OP_SLTIU: b_d = sext;
      OP_ANDI, OP_ORI, OP_XORI:   b_d = zext;
      OP_LUI: begin
        a_d = '0;
        b_d = uimm;
      end
      default:                    illegal = 1'b1;
    endcase
    vld_d = bus.in_valid;
    ill_d = illegal & bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      vld_q <= 1'b0;
      ill_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sd_q  <= '0;
    end else if (!bus.stall) begin
      vld_q <= vld_d;
      ill_q <= ill_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sd_q  <= sd_d;
    end
  end

  assign bus.out_valid      = vld_q;
  assign bus.out_illegal    = ill_q;
  assign bus.out_a          = a_q;
  assign bus.out_b          = b_q;
  assign bus.out_store_data = sd_q;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: spec-level reference model checked every cycle, plus
// hand-computed literal expectations for the directed vectors.
module tb_ex_operand_stage;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ex_operand_stage_if #(.AWIDTH(32), .OPCODE_WIDTH(6), .IMM_WIDTH(16)) bus ();

  ex_operand_stage #(.AWIDTH(32), .OPCODE_WIDTH(6), .IMM_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference state: what the EX operand register must hold.
  logic        m_vld, m_ill;
  logic [31:0] m_a, m_b, m_sd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                       input logic [31:0] ex, input logic [31:0] wb);
    if (sel == 2'd1) return ex;
    if (sel == 2'd2) return wb;
    return rf;
  endfunction

  always @(posedge clk) begin
    logic [31:0] a, b, s, imm32;
    logic        bad;
    a     = pick(bus.fwd_a_sel, bus.rs_data, bus.exmem_result, bus.memwb_result);
    s     = pick(bus.fwd_b_sel, bus.rt_data, bus.exmem_result, bus.memwb_result);
    imm32 = {16'h0, bus.imm};
    bad   = 1'b0;
    b     = 32'h0;
    if (bus.opcode == 6'h00) b = s;
    else if (bus.opcode inside {6'h23, 6'h2B, 6'h08, 6'h09, 6'h0A, 6'h0B})
      b = bus.imm[15] ? (imm32 | 32'hFFFF0000) : imm32;
    else if (bus.opcode inside {6'h0C, 6'h0D, 6'h0E}) b = imm32;
    else if (bus.opcode == 6'h0F) begin
      b = imm32 * 32'd65536;
      a = 32'h0;
    end else bad = 1'b1;
    if (!rst_n || bus.flush) begin
      m_vld = 0; m_ill = 0; m_a = 0; m_b = 0; m_sd = 0;
    end else if (!bus.stall) begin
      m_vld = bus.in_valid; m_ill = bad && bus.in_valid; m_a = a; m_b = b; m_sd = s;
    end
  end

  always @(negedge clk) begin
    chk("model_valid",   {31'h0, bus.out_valid},   {31'h0, m_vld});
    chk("model_illegal", {31'h0, bus.out_illegal}, {31'h0, m_ill});
    chk("model_a",       bus.out_a,          m_a);
    chk("model_b",       bus.out_b,          m_b);
    chk("model_sd",      bus.out_store_data, m_sd);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [15:0] imm,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input logic [31:0] ex, input logic [31:0] wb);
    bus.in_valid = v; bus.opcode = op; bus.imm = imm;
    bus.rs_data = rs; bus.rt_data = rt; bus.fwd_a_sel = fa; bus.fwd_b_sel = fb;
    bus.exmem_result = ex; bus.memwb_result = wb;
  endtask

  task automatic rnd_inputs;
    drive(1'($urandom), 6'($urandom), 16'($urandom), $urandom, $urandom,
          2'($urandom), 2'($urandom), $urandom, $urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    m_vld = 0; m_ill = 0; m_a = 0; m_b = 0; m_sd = 0;
    rnd_inputs();
    tick();
    rnd_inputs();
    tick();
    chk("rst_valid",   {31'h0, bus.out_valid}, 32'h0);
    chk("rst_illegal", {31'h0, bus.out_illegal}, 32'h0);
    chk("rst_a",  bus.out_a, 32'h0);
    chk("rst_b",  bus.out_b, 32'h0);
    chk("rst_sd", bus.out_store_data, 32'h0);

    rst_n = 1'b1;
    drive(0, 6'h08, 16'h1, 32'h1, 32'h2, 2'b00, 2'b00, 32'h0, 32'h0);
    tick();
    chk("idle_valid", {31'h0, bus.out_valid}, 32'h0);

    drive(1, 6'h08, 16'hFFFC, 32'h10, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    tick();
    chk("addi_a", bus.out_a, 32'h10);
    chk("addi_b", bus.out_b, 32'hFFFFFFFC);
    chk("addi_valid", {31'h0, bus.out_valid}, 32'h1);

    drive(1, 6'h0D, 16'hFFFC, 32'h10, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    tick();
    chk("ori_b", bus.out_b, 32'h0000FFFC);

    drive(1, 6'h0F, 16'h1234, 32'h10, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    tick();
    chk("lui_a", bus.out_a, 32'h0);
    chk("lui_b", bus.out_b, 32'h12340000);

    drive(1, 6'h00, 16'h0, 32'h1, 32'h7, 2'b01, 2'b10, 32'hAAAA0001, 32'h5555);
    tick();
    chk("rtype_a",  bus.out_a, 32'hAAAA0001);
    chk("rtype_b",  bus.out_b, 32'h5555);
    chk("rtype_sd", bus.out_store_data, 32'h5555);

    drive(1, 6'h00, 16'h0, 32'h31, 32'h32, 2'b11, 2'b11, 32'hEE, 32'hFF);
    tick();
    chk("fwd11_a", bus.out_a, 32'h31);
    chk("fwd11_b", bus.out_b, 32'h32);

    drive(1, 6'h2B, 16'h0008, 32'h100, 32'hDEADBEEF, 2'b00, 2'b00, 32'h0, 32'h0);
    tick();
    chk("store_b",  bus.out_b, 32'h8);
    chk("store_sd", bus.out_store_data, 32'hDEADBEEF);

    drive(1, 6'h09, 16'h8000, 32'h44, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    tick();
    chk("addiu_b", bus.out_b, 32'hFFFF8000);
    chk("addiu_a", bus.out_a, 32'h44);

    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rnd_inputs();
      tick();
      chk("stall_a", bus.out_a, 32'h44);
      chk("stall_b", bus.out_b, 32'hFFFF8000);
      chk("stall_valid", {31'h0, bus.out_valid}, 32'h1);
    end
    bus.flush = 1'b1;
    tick();
    chk("flush_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("flush_a", bus.out_a, 32'h0);
    chk("flush_b", bus.out_b, 32'h0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1, 6'h0C, 16'h8001, 32'h55, 32'h66, 2'b00, 2'b00, 32'h0, 32'h0);
    tick();
    chk("release_a", bus.out_a, 32'h55);
    chk("release_b", bus.out_b, 32'h00008001);
    chk("release_valid", {31'h0, bus.out_valid}, 32'h1);

    drive(1, 6'h3F, 16'h1234, 32'h1, 32'h2, 2'b00, 2'b00, 32'h0, 32'h0);
    tick();
    chk("ill_flag", {31'h0, bus.out_illegal}, 32'h1);
    chk("ill_b", bus.out_b, 32'h0);
    bus.in_valid = 1'b0;
    tick();
    chk("ill_nv_flag",  {31'h0, bus.out_illegal}, 32'h0);
    chk("ill_nv_valid", {31'h0, bus.out_valid}, 32'h0);

    drive(1, 6'h23, 16'h0004, 32'h77, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    tick();
    bus.stall = 1'b1;
    rst_n = 1'b0;
    tick();
    chk("rst_stall_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_stall_a", bus.out_a, 32'h0);
    rst_n = 1'b1;
    bus.stall = 1'b0;

    for (int i = 0; i < 40; i++) begin
      rnd_inputs();
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      tick();
    end
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
